// File: rtl/pipe_pkg.sv
// Shared encodings for the RV32I pipeline hazard/sequencing controller.
package pipe_pkg;

    localparam logic [1:0] WB_PC4 = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } ctrl_state_e;

    function automatic logic is_mem_access(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one source register; M result beats W result.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_wr_m,
    input  logic       reg_wr_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        // x0 is hardwired to zero, so a write to it must never be forwarded
        if (reg_wr_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd = FWD_M;
        end else if (reg_wr_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch flushes, forwarding selects and
// multi-cycle data-memory freeze with a timeout trap.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1D,
    input  logic [4:0]        rs2D,
    input  logic [4:0]        rs1E,
    input  logic [4:0]        rs2E,
    input  logic [4:0]        rdE,
    input  logic [4:0]        rdM,
    input  logic [4:0]        rdW,
    input  logic              reg_wrE,
    input  logic              reg_wrM,
    input  logic              reg_wrW,
    input  logic [1:0]        wb_selE,
    input  logic [6:0]        instr_opcodeM,
    input  logic              br_takenE,
    input  logic              dmem_ready,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic [1:0]        fwdAE,
    output logic [1:0]        fwdBE,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0]   CntOne   = CntW'(1);
    localparam logic [CntW-1:0]   CntMax   = CntW'(MEM_TIMEOUT);
    localparam logic [PERF_W-1:0] StallOne = PERF_W'(1);

    ctrl_state_e       state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic       mem_access;
    logic       load_use;
    logic       frozen;
    logic       stall_any;
    logic [1:0] fwd_a, fwd_b;

    assign mem_access = is_mem_access(instr_opcodeM);
    assign load_use   = (wb_selE == WB_MEM) && reg_wrE && (rdE != 5'd0) &&
                        ((rdE == rs1D) || (rdE == rs2D));

    fwd_unit u_fwd_a (
        .rs_e     (rs1E),
        .rd_m     (rdM),
        .rd_w     (rdW),
        .reg_wr_m (reg_wrM),
        .reg_wr_w (reg_wrW),
        .fwd      (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_e     (rs2E),
        .rd_m     (rdM),
        .rd_w     (rdW),
        .reg_wr_m (reg_wrM),
        .reg_wr_w (reg_wrW),
        .fwd      (fwd_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CntOne;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CntMax) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntOne;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        mem_err_d = mem_err_q | (state_d == ERR);

        stall_cnt_d = stall_cnt_q;
        if (stall_any && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + StallOne;
        end
    end

    // The MEM-stage instruction stays put while frozen, so MEM_WAIT need not re-check the opcode
    assign frozen = (state_q == ERR) ||
                    (!dmem_ready && ((state_q == MEM_WAIT) || ((state_q == RUN) && mem_access)));

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        fwdAE  = FWD_RF;
        fwdBE  = FWD_RF;
        if (!rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushW = 1'b1;
        end else begin
            fwdAE = fwd_a;
            fwdBE = fwd_b;
            if (frozen) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (br_takenE) begin
                // D holds a wrong-path instruction, so a pending load-use stall is moot
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    assign stall_any = stallF | stallD | stallE | stallM;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic.
module tb_pipeline_ctrl;

    localparam int unsigned MemTimeout = 16;
    localparam int unsigned PerfW      = 8;
    localparam int          CntSat     = (1 << PerfW) - 1;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpAlu   = 7'b0110011;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             reg_wrE, reg_wrM, reg_wrW;
    logic [1:0]       wb_selE;
    logic [6:0]       instr_opcodeM;
    logic             br_takenE, dmem_ready;
    logic             stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]       fwdAE, fwdBE;
    logic             mem_err;
    logic [PerfW-1:0] stall_cnt;

    pipeline_ctrl #(
        .MEM_TIMEOUT (MemTimeout),
        .PERF_W      (PerfW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1D          (rs1D),
        .rs2D          (rs2D),
        .rs1E          (rs1E),
        .rs2E          (rs2E),
        .rdE           (rdE),
        .rdM           (rdM),
        .rdW           (rdW),
        .reg_wrE       (reg_wrE),
        .reg_wrM       (reg_wrM),
        .reg_wrW       (reg_wrW),
        .wb_selE       (wb_selE),
        .instr_opcodeM (instr_opcodeM),
        .br_takenE     (br_takenE),
        .dmem_ready    (dmem_ready),
        .stallF        (stallF),
        .stallD        (stallD),
        .stallE        (stallE),
        .stallM        (stallM),
        .flushD        (flushD),
        .flushE        (flushE),
        .flushW        (flushW),
        .fwdAE         (fwdAE),
        .fwdBE         (fwdBE),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       s_f, s_d, s_e, s_m, f_d, f_e, f_w, err;
        logic [1:0] fa, fb;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state: how many consecutive frozen cycles the current access has waited,
    // whether the trap has fired, and total stall cycles.
    int   m_waited = 0;
    bit   m_err    = 0;
    int   m_cnt    = 0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] r_m,
                                           input logic w_m, input logic [4:0] r_w,
                                           input logic w_w);
        if (w_m && r_m != 0 && r_m == rs) return 2'b10;
        if (w_w && r_w != 0 && r_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string name, input int got, input int want, input int c);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL cyc=%0d %s got=%0d expected=%0d", c, name, got, want);
        end
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, then advance the
    // reference model across the coming clock edge.
    task automatic step();
        exp_t e;
        bit   access, frozen, luse, any;
        e = '{cyc: cyc, s_f: 0, s_d: 0, s_e: 0, s_m: 0, f_d: 0, f_e: 0, f_w: 0, err: 0,
              fa: 2'b00, fb: 2'b00, cnt: 0};
        if (!rst) begin
            m_waited = 0;
            m_err    = 0;
            m_cnt    = 0;
            e.f_d = 1; e.f_e = 1; e.f_w = 1;
        end else begin
            access = (instr_opcodeM == OpLoad) || (instr_opcodeM == OpStore);
            frozen = m_err || (!dmem_ready && (m_waited > 0 || access));
            luse   = (wb_selE == 2'b10) && reg_wrE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
            e.fa = ref_fwd(rs1E, rdM, reg_wrM, rdW, reg_wrW);
            e.fb = ref_fwd(rs2E, rdM, reg_wrM, rdW, reg_wrW);
            if (frozen) begin
                e.s_f = 1; e.s_d = 1; e.s_e = 1; e.s_m = 1; e.f_w = 1;
            end else if (br_takenE) begin
                e.f_d = 1; e.f_e = 1;
            end else if (luse) begin
                e.s_f = 1; e.s_d = 1; e.f_e = 1;
            end
        end
        e.err = m_err;
        e.cnt = m_cnt;
        sb_q.push_back(e);
        if (rst) begin
            any = e.s_f || e.s_d || e.s_e || e.s_m;
            if (any && m_cnt < CntSat) m_cnt++;
            if (!m_err) begin
                if (e.s_m) begin
                    m_waited++;
                    if (m_waited > MemTimeout) m_err = 1;
                end else begin
                    m_waited = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("stallF", int'(stallF), int'(e.s_f), e.cyc);
            check("stallD", int'(stallD), int'(e.s_d), e.cyc);
            check("stallE", int'(stallE), int'(e.s_e), e.cyc);
            check("stallM", int'(stallM), int'(e.s_m), e.cyc);
            check("flushD", int'(flushD), int'(e.f_d), e.cyc);
            check("flushE", int'(flushE), int'(e.f_e), e.cyc);
            check("flushW", int'(flushW), int'(e.f_w), e.cyc);
            check("fwdAE", int'(fwdAE), int'(e.fa), e.cyc);
            check("fwdBE", int'(fwdBE), int'(e.fb), e.cyc);
            check("mem_err", int'(mem_err), int'(e.err), e.cyc);
            check("stall_cnt", int'(stall_cnt), e.cnt, e.cyc);
        end
    end

    task automatic idle_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        reg_wrE = 0; reg_wrM = 0; reg_wrW = 0; wb_selE = 2'b01;
        instr_opcodeM = OpAlu; br_takenE = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        step();
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Load x5 in E, D reads x5; then load reaches W and is forwarded
        wb_selE = 2'b10; reg_wrE = 1; rdE = 5; rs1D = 5;
        step();
        idle_inputs(); rdM = 5; reg_wrM = 1; instr_opcodeM = OpLoad; rs1E = 5;
        step();
        idle_inputs(); rdW = 5; reg_wrW = 1; rs1E = 5;
        step();

        // Load in M with memory not ready for three cycles
        do_reset();
        idle_inputs(); instr_opcodeM = OpLoad; dmem_ready = 0;
        repeat (3) step();
        dmem_ready = 1;
        step();
        idle_inputs();
        step();

        // Forwarding priority and x0
        rdM = 7; rdW = 7; rs1E = 7; rs2E = 7; reg_wrM = 1; reg_wrW = 1;
        step();
        rdM = 0; rdW = 0; rs1E = 0; rs2E = 0;
        step();

        // Branch with simultaneous load-use; then branch held during a memory wait
        idle_inputs(); wb_selE = 2'b10; reg_wrE = 1; rdE = 3; rs2D = 3; br_takenE = 1;
        step();
        instr_opcodeM = OpStore; dmem_ready = 0;
        repeat (2) step();
        dmem_ready = 1;
        step();

        // Reset pulled mid-wait
        idle_inputs(); instr_opcodeM = OpLoad; dmem_ready = 0;
        repeat (2) step();
        rst = 0;
        step();
        rst = 1;
        step();
        dmem_ready = 1;
        step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int sel;
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            reg_wrE = 1'($urandom); reg_wrM = 1'($urandom); reg_wrW = 1'($urandom);
            wb_selE = 2'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 3));
            instr_opcodeM = (sel == 0) ? OpLoad : (sel == 1) ? OpStore : OpAlu;
            dmem_ready = ($urandom_range(0, 3) != 0);
            br_takenE  = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 199) != 0);
            step();
        end

        // Timeout trap, stall counter saturation, freeze held until reset
        rst = 1;
        idle_inputs();
        step();
        do_reset();
        instr_opcodeM = OpLoad; dmem_ready = 0;
        repeat (300) step();
        idle_inputs(); br_takenE = 1;
        repeat (3) step();
        do_reset();
        idle_inputs();
        step();

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives stall/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and EX-stage operand forwarding selects.
- Sequences multi-cycle data-memory accesses through a ready handshake, with a timeout trap.
- Sits beside the datapath; all pipeline registers take their enable/clear from this block.

Parameters:
- MEM_TIMEOUT, 16, max cycles a MEM-stage access may wait for dmem_ready before the error trap.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rs1D, rs2D  in  5  source regs of instruction in D
- rs1E, rs2E  in  5  source regs of instruction in E
- rdE, rdM, rdW  in  5  destination regs in E/M/W
- reg_wrE, reg_wrM, reg_wrW  in  1  register-write enables per stage
- wb_selE  in  2  writeback select of instruction in E
- instr_opcodeM  in  7  opcode of instruction in M
- br_takenE  in  1  branch/jump redirect resolved in E
- dmem_ready  in  1  data memory completes access this cycle
- stallF, stallD, stallE, stallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- flushD, flushE, flushW  out  1  load bubble into IF-ID / ID-EX / MEM-WB
- fwdAE, fwdBE  out  2  EX operand select: 00 regfile, 01 W result, 10 M ALUResult
- mem_err  out  1  timeout trap, sticky
- stall_cnt  out  PERF_W  total stall cycles, saturating

Behaviour:
- Registered state: fsm (RUN, MEM_WAIT, ERR), wait counter (clog2(MEM_TIMEOUT+1) bits), stall_cnt, mem_err. Control outputs are combinational from inputs and state.
- Reset (rst=0):
  - fsm=RUN, wait counter=0, stall_cnt=0, mem_err=0.
  - Combinational outputs forced: all stalls 0, flushD/flushE/flushW=1, fwd=00.
  - Reset asserted mid-wait aborts the access immediately.
- Memory access = instr_opcodeM is LOAD (0000011) or STORE (0100011).
- RUN:
  - Access with dmem_ready=0 → assert stallF/D/E/M and flushW this cycle; next state MEM_WAIT, counter=1.
  - Access with dmem_ready=1 → no freeze.
- MEM_WAIT:
  - Freeze held (stallF/D/E/M=1, flushW=1) while dmem_ready=0; counter increments.
  - dmem_ready=1 → freeze released that same cycle, return to RUN, counter=0.
  - Counter==MEM_TIMEOUT and still not ready → ERR.
- ERR: mem_err=1, freeze held permanently until reset.
- Load-use, evaluated only when not frozen:
  - Condition: wb_selE==WB_MEM and reg_wrE and rdE!=0 and (rdE==rs1D or rdE==rs2D).
  - Response: stallF=stallD=1 and flushE=1 for exactly one cycle.
- Branch (br_takenE, not frozen): flushD=flushE=1. Branch overrides load-use in the same cycle: no stallF/stallD, since the D instruction is wrong-path.
- Freeze priority:
  - Freeze overrides branch and load-use; E is held, so br_takenE re-presents and flushes on release.
  - flushD/flushE are 0 while frozen.
- Forwarding, per operand, e.g. fwdAE:
  - 10 if reg_wrM and rdM!=0 and rdM==rs1E.
  - else 01 if reg_wrW and rdW!=0 and rdW==rs1E.
  - else 00.
  - M beats W. x0 is never forwarded. Same rule for fwdBE with rs2E.
- stall_cnt:
  - Increments by 1 each cycle any of stallF/stallD/stallE/stallM is 1.
  - Saturates at all-ones; no wrap.

Decomposition:
- Package pipe_pkg:
  - wb_sel encodings WB_PC4=2'b00, WB_ALU=2'b01, WB_MEM=2'b10.
  - OPC_LOAD, OPC_STORE.
  - Forwarding encodings FWD_RF/FWD_W/FWD_M.
  - ctrl_state_e enum {RUN, MEM_WAIT, ERR}.
- One sub-module fwd_unit: purely combinational, instanced twice (operands A and B).
- FSM and counters stay in the top.

Test Plan:
- Load to x5 in E, D reads x5 → stallF=stallD=flushE=1 for 1 cycle; next cycle fwd from W for x5 selects 01.
- Load in M, dmem_ready low 3 cycles → stallF/D/E/M=1, flushW=1 for 3 cycles; release on 4th; stall_cnt=3.
- dmem_ready held low, MEM_TIMEOUT=16 → ERR entered after 16 wait cycles; mem_err=1, freeze persists until rst=0.
- rdM=rdW=rs1E=7, both writing → fwdAE=10. rdM=rdW=rs1E=0 → fwdAE=00.
- br_takenE=1 with simultaneous load-use → flushD=flushE=1, stallF=stallD=0. Same branch during MEM_WAIT → no flush until release, then flushD=flushE=1.
- rst pulled low in MEM_WAIT cycle 2 → fsm=RUN, counters 0, flushes asserted asynchronously.
